// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : PLIC-style interrupt priority arbiter with per-source
//                gateways, max-finder selection and claim/complete handshake.
//                Optional macro IRQ_ARB_EDGE_EN selects rising-edge gateways.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_arbiter #(
    parameter int SRC_N  = 31,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(SRC_N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SRC_N-1:0]  i_src,
    input  logic              i_wr_en,
    input  logic [ID_W-1:0]   i_wr_addr,
    input  logic [PRIO_W-1:0] i_wr_data,
    input  logic              i_claim,
    input  logic              i_complete,
    input  logic [ID_W-1:0]   i_complete_id,
    output logic              o_irq,
    output logic [ID_W-1:0]   o_claim_id,
    output logic [SRC_N-1:0]  o_pending
);

    localparam int C_LVLS   = (SRC_N > 1) ? $clog2(SRC_N) : 0;
    localparam int C_LEAVES = 1 << C_LVLS;
    localparam int C_NODES  = 2 * C_LEAVES - 1;

    logic [PRIO_W-1:0] prio_q [SRC_N];
    logic [PRIO_W-1:0] prio_d [SRC_N];
    logic [PRIO_W-1:0] thresh_q, thresh_d;
    logic [SRC_N-1:0]  pending_q, pending_d;
    logic [SRC_N-1:0]  busy_q, busy_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic [ID_W-1:0]   claim_id_q, claim_id_d;
    logic              irq_q, irq_d;

    logic [SRC_N-1:0]  w_trig;
    logic [ID_W-1:0]   w_eff_id;
    logic [PRIO_W-1:0] w_tree_val [C_NODES];
    logic [ID_W-1:0]   w_tree_id  [C_NODES];

`ifdef IRQ_ARB_EDGE_EN
    logic [SRC_N-1:0] src_dly_q, src_dly_d;

    assign src_dly_d = i_src;
    assign w_trig    = i_src & ~src_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) src_dly_q <= '0;
        else        src_dly_q <= src_dly_d;
    end
`else
    assign w_trig = i_src;
`endif

    assign w_eff_id = irq_q ? best_id_q : '0;

    // Heap-ordered max finder: left child always covers lower IDs, so >= favours them on ties.
    always_comb begin
        for (int j = 0; j < C_LEAVES; j++) begin
            w_tree_val[C_LEAVES-1+j] = '0;
            w_tree_id[C_LEAVES-1+j]  = '0;
        end
        for (int j = 0; j < SRC_N; j++) begin
            w_tree_val[C_LEAVES-1+j] = pending_q[j] ? prio_q[j] : '0;
            w_tree_id[C_LEAVES-1+j]  = ID_W'(j + 1);
        end
        for (int i = C_LEAVES - 2; i >= 0; i--) begin
            if (w_tree_val[2*i+1] >= w_tree_val[2*i+2]) begin
                w_tree_val[i] = w_tree_val[2*i+1];
                w_tree_id[i]  = w_tree_id[2*i+1];
            end else begin
                w_tree_val[i] = w_tree_val[2*i+2];
                w_tree_id[i]  = w_tree_id[2*i+2];
            end
        end
    end

    always_comb begin
        thresh_d   = thresh_q;
        prio_d     = prio_q;
        pending_d  = pending_q | (w_trig & ~busy_q);
        busy_d     = busy_q;
        claim_id_d = claim_id_q;

        if (i_wr_en && (i_wr_addr == '0)) thresh_d = i_wr_data;

        for (int k = 0; k < SRC_N; k++) begin
            if (i_wr_en && (i_wr_addr == ID_W'(k + 1))) prio_d[k] = i_wr_data;
            if (i_complete && (i_complete_id == ID_W'(k + 1)) && busy_q[k]) busy_d[k] = 1'b0;
            if (i_claim && (w_eff_id == ID_W'(k + 1))) begin
                pending_d[k] = 1'b0;
                busy_d[k]    = 1'b1;
            end
        end

        // A claim blanks the best registers so a back-to-back claim sees nothing.
        if (i_claim) begin
            claim_id_d = w_eff_id;
            best_id_d  = '0;
            irq_d      = 1'b0;
        end else begin
            best_id_d  = w_tree_id[0];
            irq_d      = (w_tree_val[0] > thresh_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SRC_N; k++) prio_q[k] <= '0;
            thresh_q   <= '0;
            pending_q  <= '0;
            busy_q     <= '0;
            best_id_q  <= '0;
            claim_id_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            thresh_q   <= thresh_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            best_id_q  <= best_id_d;
            claim_id_q <= claim_id_d;
            irq_q      <= irq_d;
        end
    end

    assign o_irq      = irq_q;
    assign o_claim_id = claim_id_q;
    assign o_pending  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_arbiter
//  Description : Directed self-checking bench for irq_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_arbiter;

    localparam int SRC_N  = 31;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SRC_N-1:0]  i_src;
    logic              i_wr_en;
    logic [ID_W-1:0]   i_wr_addr;
    logic [PRIO_W-1:0] i_wr_data;
    logic              i_claim;
    logic              i_complete;
    logic [ID_W-1:0]   i_complete_id;
    logic              o_irq;
    logic [ID_W-1:0]   o_claim_id;
    logic [SRC_N-1:0]  o_pending;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.SRC_N(SRC_N), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_src         (i_src),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_claim       (i_claim),
        .i_complete    (i_complete),
        .i_complete_id (i_complete_id),
        .o_irq         (o_irq),
        .o_claim_id    (o_claim_id),
        .o_pending     (o_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        i_src         = '0;
        i_wr_en       = 1'b0;
        i_wr_addr     = '0;
        i_wr_data     = '0;
        i_claim       = 1'b0;
        i_complete    = 1'b0;
        i_complete_id = '0;
        rst_n         = 1'b0;
        tick();
        rst_n         = 1'b1;
    endtask

    task automatic wr(input int addr, input int data);
        i_wr_en   = 1'b1;
        i_wr_addr = ID_W'(addr);
        i_wr_data = PRIO_W'(data);
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic claim();
        i_claim = 1'b1;
        tick();
        i_claim = 1'b0;
    endtask

    task automatic complete(input int id);
        i_complete    = 1'b1;
        i_complete_id = ID_W'(id);
        tick();
        i_complete    = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_claim", 32'(o_claim_id), 32'd0);
        check("rst_pend", 32'(o_pending), 32'd0);

        // Basic latency and claim
        wr(3, 5);
        wr(0, 0);
        i_src[2] = 1'b1;
        tick();
        check("lat_pend", 32'(o_pending[2]), 32'd1);
        check("lat_irq1", 32'(o_irq), 32'd0);
        tick();
        check("lat_irq2", 32'(o_irq), 32'd1);
        claim();
        check("c1_id", 32'(o_claim_id), 32'd3);
        check("c1_pend", 32'(o_pending[2]), 32'd0);
        check("c1_irq", 32'(o_irq), 32'd0);

        // Priority ordering and ties
        do_reset();
        wr(2, 4);
        wr(5, 4);
        wr(7, 6);
        i_src = '1;
        tick();
        tick();
        claim();
        check("pri_7", 32'(o_claim_id), 32'd7);
        i_src[6] = 1'b0;
        complete(7);
        claim();
        check("tie_2", 32'(o_claim_id), 32'd2);
        tick();
        claim();
        check("tie_5", 32'(o_claim_id), 32'd5);
        tick();
        check("zero_prio_irq", 32'(o_irq), 32'd0);
        check("busy_pend", 32'(o_pending), 32'h7FFF_FFAD);

        // Back-to-back claims
        do_reset();
        wr(4, 2);
        wr(6, 5);
        i_src[3] = 1'b1;
        i_src[5] = 1'b1;
        tick();
        tick();
        i_claim = 1'b1;
        tick();
        check("b2b_first", 32'(o_claim_id), 32'd6);
        tick();
        check("b2b_second", 32'(o_claim_id), 32'd0);
        i_claim = 1'b0;
        tick();
        check("b2b_irq", 32'(o_irq), 32'd1);
        claim();
        check("b2b_third", 32'(o_claim_id), 32'd4);

        // Threshold
        do_reset();
        wr(0, 5);
        wr(1, 5);
        i_src[0] = 1'b1;
        tick();
        tick();
        tick();
        check("thr_irq_lo", 32'(o_irq), 32'd0);
        claim();
        check("thr_claim0", 32'(o_claim_id), 32'd0);
        check("thr_pend", 32'(o_pending[0]), 32'd1);
        wr(0, 4);
        check("thr_irq_1cyc", 32'(o_irq), 32'd0);
        tick();
        check("thr_irq_2cyc", 32'(o_irq), 32'd1);

        // Busy / complete handling
        do_reset();
        wr(9, 3);
        i_src[8] = 1'b1;
        tick();
        tick();
        claim();
        check("cmp_claim9", 32'(o_claim_id), 32'd9);
        tick();
        tick();
        check("cmp_nore", 32'(o_pending[8]), 32'd0);
        complete(10);
        tick();
        tick();
        check("cmp_bad_id", 32'(o_pending[8]), 32'd0);
        complete(9);
        tick();
`ifdef IRQ_ARB_EDGE_EN
        check("cmp_repend", 32'(o_pending[8]), 32'd0);
        tick();
        check("cmp_reirq", 32'(o_irq), 32'd0);
`else
        check("cmp_repend", 32'(o_pending[8]), 32'd1);
        tick();
        check("cmp_reirq", 32'(o_irq), 32'd1);
`endif

        // Mid-operation reset
        do_reset();
        wr(1, 1);
        wr(2, 1);
        wr(3, 1);
        i_src[2:0] = 3'b111;
        tick();
        tick();
        check("mr_pend", 32'(o_pending), 32'h7);
        check("mr_irq", 32'(o_irq), 32'd1);
        claim();
        check("mr_claim", 32'(o_claim_id), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_rst_irq", 32'(o_irq), 32'd0);
        check("mr_rst_pend", 32'(o_pending), 32'd0);
        check("mr_rst_claim", 32'(o_claim_id), 32'd0);
        tick();
        tick();
        tick();
        check("mr_after_pend", 32'(o_pending), 32'h7);
        check("mr_after_irq", 32'(o_irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt priority arbiter for the machine's external-interrupt path (PLIC-style core). It latches up to SRC_N level-triggered sources through per-source gateways and holds a programmable priority per source. Each cycle it selects the highest-priority pending source above a threshold using a `max_finder` tree, with the priority as the value and the source ID as the payload. It serves a claim/complete handshake to the hart-side CSR/MMIO logic.

## Interface
- SRC_N, 31, number of sources; IDs 1..SRC_N, ID 0 means "no interrupt"
- PRIO_W, 3, priority/threshold width
- ID_W, $clog2(SRC_N+1), source ID width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i_src  in  SRC_N  raw level interrupt lines; bit k-1 is source k
- i_wr_en  in  1  config write strobe
- i_wr_addr  in  ID_W  0 writes threshold; k in 1..SRC_N writes priority[k]; k>SRC_N ignored
- i_wr_data  in  PRIO_W  write data
- i_claim  in  1  one-cycle claim strobe
- i_complete  in  1  one-cycle complete strobe
- i_complete_id  in  ID_W  ID being completed
- o_irq  out  1  registered; high when best pending priority > threshold
- o_claim_id  out  ID_W  ID returned by the most recent claim; held until next claim
- o_pending  out  SRC_N  pending bits, for readback

## Operation
- Per-source state: prio[k], pending[k], busy[k]. Global state: thresh, best_id, best_prio.
- Gateway without IRQ_ARB_EDGE_EN: a cycle with i_src[k]=1, pending[k]=0 and busy[k]=0 sets pending[k] on the next edge.
- Selection is combinational. Source k's value is prio[k] when pending[k], else 0; its payload is k. Channel 0 is source 1.
  - The result is registered into best_prio/best_id.
  - Ties go to the lowest ID.
  - Priority 0 never wins, because the value must exceed thresh.
- o_irq = (best_prio > thresh), registered with the best regs. Effective best_id = best_id when o_irq, else 0.
- Claim (i_claim=1):
  - o_claim_id ← effective best_id.
  - If nonzero: pending[id] cleared, busy[id] set.
  - best_prio/best_id/o_irq forced to 0 on the next edge, so a back-to-back claim returns 0.
- Complete: if 1 ≤ i_complete_id ≤ SRC_N and busy[id]=1, clear busy[id]. Otherwise ignored, with no error.
- Config writes take effect on the next edge. The new values are used by the selection one cycle later.
- Reset: prio=0, thresh=0, pending=0, busy=0, best_prio=0, best_id=0, o_irq=0, o_claim_id=0.

## Timing
- Source assert at edge N sets pending at N+1, and o_irq/best at N+2. Latency is 2 cycles.
- Claim at cycle C:
  - o_claim_id valid after edge C.
  - o_irq low after edge C.
  - Next candidate visible after edge C+1.
- Complete at cycle C with the line still high: busy cleared at C+1, pending re-set at C+2, o_irq at C+3.
- Simultaneous claim + config write to the claimed source's priority: the claim returns the registered best_id. The write applies normally.
- Simultaneous claim + complete of a different ID: both apply.
- Complete of the ID being claimed in the same cycle: ignored, since busy is not yet set.
- A threshold raised above best_prio drops o_irq 2 cycles after the write strobe.
- rst_n low mid-operation: all state returns to reset values on that edge, and outstanding busy bits are lost.

## Configuration
- IRQ_ARB_EDGE_EN defined:
  - Gateways are rising-edge triggered. A per-source i_src delay register (reset 0) is added.
  - pending[k] sets when i_src[k] goes from 0 to 1 while busy[k]=0.
  - An edge arriving while busy or pending is dropped.
  - A source held high after complete does not re-fire.
- Not defined: level-triggered gateways as in Operation. There is no delay register.

## Test plan
- Reset, then prio[3]=5, thresh=0. Drive i_src[2]=1 (source 3) at cycle 0 → o_irq=1 at cycle 2. Claim → o_claim_id=3, o_pending[2]=0.
- prio[2]=4, prio[5]=4, prio[7]=6, all sources asserted → claim returns 7. Complete 7 with its line low, then claim → 2 (tie broken by lowest ID), then claim → 5.
- Claim on two consecutive cycles with sources 4 and 6 pending → first returns the higher-priority ID, second returns 0. A third claim one cycle later returns the other ID.
- thresh=5, prio[1]=5, source 1 asserted → o_irq stays 0 and claim returns 0. Set thresh=4 → o_irq=1 two cycles after the write.
- Claim source 9 with its line held high → no re-pend while busy. i_complete_id=10 (not busy) is ignored. i_complete_id=9 → pending[8]=1 two cycles later (level build). With IRQ_ARB_EDGE_EN, no re-pend occurs.
- Pend sources 1..3, assert rst_n=0 for one cycle → o_irq=0, o_pending=0, o_claim_id=0. Priorities read as 0, so no interrupt fires afterward.
